// File: rtl/sram_req_ctrl.sv
// Request front-end for a single-port SRAM macro: arbitrates independent read and
// write request streams onto the RW port and buffers read data in a credit-protected queue.
module sram_req_ctrl #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 256,
    parameter int MASK_W      = DATA_W / 8,
    parameter int RESP_DEPTH  = 2,
    parameter int WSTREAK_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              io_wreq_valid,
    output logic              io_wreq_ready,
    input  logic [ADDR_W-1:0] io_wreq_addr,
    input  logic [DATA_W-1:0] io_wreq_data,
    input  logic [MASK_W-1:0] io_wreq_mask,

    input  logic              io_rreq_valid,
    output logic              io_rreq_ready,
    input  logic [ADDR_W-1:0] io_rreq_addr,

    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [DATA_W-1:0] io_resp_data,

    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int WS_W  = $clog2(WSTREAK_MAX + 1);
    localparam logic [WS_W-1:0]  WSTREAK_LIM = WS_W'(WSTREAK_MAX);
    localparam logic [CNT_W:0]   DEPTH_LIM   = (CNT_W + 1)'(RESP_DEPTH);

    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [WS_W-1:0]   wstreak;
    logic [WS_W-1:0]   wstreak_next;
    logic [DATA_W-1:0] queue [RESP_DEPTH];

    logic [CNT_W:0]    occupancy;
    logic              credit_ok;
    logic              read_elig;
    logic              gnt_w;
    logic              gnt_r;
    logic              enq;
    logic              deq;

    // The read issued last cycle already owns a slot, so it counts against credit.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign credit_ok = occupancy < DEPTH_LIM;

    assign read_elig = io_rreq_valid && credit_ok && !reset;
    assign gnt_w     = io_wreq_valid && !reset && !(read_elig && wstreak == WSTREAK_LIM);
    assign gnt_r     = read_elig && !gnt_w;

    assign io_wreq_ready = gnt_w;
    assign io_rreq_ready = gnt_r;

    assign enq           = inflight;
    assign io_resp_valid = (count != '0);
    assign deq           = io_resp_valid && io_resp_ready;
    assign io_resp_data  = queue[rd_ptr];

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        sram_en    = gnt_w | gnt_r;
        sram_wmode = gnt_w;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (gnt_w) begin
            sram_addr  = io_wreq_addr;
            sram_wmask = io_wreq_mask;
            sram_wdata = io_wreq_data;
        end else if (gnt_r) begin
            sram_addr  = io_rreq_addr;
        end
    end

    always_comb begin
        wstreak_next = '0;
        if (gnt_w && read_elig) begin
            wstreak_next = (wstreak == WSTREAK_LIM) ? wstreak : wstreak + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            wstreak  <= '0;
        end else begin
            inflight <= gnt_r;
            wstreak  <= wstreak_next;
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq) begin
                count <= count + 1'b1;
            end else if (deq && !enq) begin
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: the data array is not reset; count gates every read of it.
    always_ff @(posedge clock) begin
        if (enq) begin
            queue[wr_ptr] <= sram_rdata;
        end
    end

endmodule
